// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction encodings, ALU operations and the
// multicycle controller's state, error and instruction-class enums.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_MEM_TIMEOUT = 2'd1,
    ERR_ILLEGAL     = 2'd2,
    ERR_OVERFLOW    = 2'd3
  } ctrl_err_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_JR
  } instr_class_t;

  // PC source select
  localparam logic [1:0] PCSRC_NEXT   = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_BRANCH = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // Register destination select
  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  // Writeback source select
  localparam logic [1:0] WBSRC_ALU   = 2'd0;
  localparam logic [1:0] WBSRC_DLOAD = 2'd1;
  localparam logic [1:0] WBSRC_PC4   = 2'd2;

  // ALU port B select
  localparam logic [1:0] SRC_RT    = 2'd0;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_UPPER = 2'd2;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: opcode/funct to static datapath
// controls, instruction class and an illegal-encoding flag.
module instr_decoder
  import cpu_types_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctr_o,
  output logic [1:0] alu_src_o,
  output logic       ext_op_o,
  output logic       rtype_o,
  output logic       shamt_sel_o,
  output logic [2:0] iclass_o,
  output logic       ovf_chk_o,
  output logic       illegal_o
);

  aluop_t       alu_ctr;
  instr_class_t iclass;

  assign alu_ctr_o = alu_ctr;
  assign iclass_o  = iclass;

  // Opcode/funct decode into datapath controls
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_ctr     = ALU_ADD;
    alu_src_o   = SRC_RT;
    ext_op_o    = 1'b1;
    rtype_o     = 1'b0;
    shamt_sel_o = 1'b0;
    iclass      = CLS_ALU;
    ovf_chk_o   = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        rtype_o = 1'b1;
        case (funct_i)
          FN_SLL:  begin alu_ctr = ALU_SLL; shamt_sel_o = 1'b1; end
          FN_SRL:  begin alu_ctr = ALU_SRL; shamt_sel_o = 1'b1; end
          FN_JR:   iclass = CLS_JR;
          FN_ADD:  ovf_chk_o = 1'b1;
          FN_ADDU: alu_ctr = ALU_ADD;
          FN_SUB:  begin alu_ctr = ALU_SUB; ovf_chk_o = 1'b1; end
          FN_SUBU: alu_ctr = ALU_SUB;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_XOR:  alu_ctr = ALU_XOR;
          FN_NOR:  alu_ctr = ALU_NOR;
          FN_SLT:  alu_ctr = ALU_SLT;
          FN_SLTU: alu_ctr = ALU_SLTU;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_J:     iclass = CLS_J;
      OP_JAL:   iclass = CLS_JAL;
      OP_BEQ:   begin iclass = CLS_BEQ; alu_ctr = ALU_SUB; end
      OP_BNE:   begin iclass = CLS_BNE; alu_ctr = ALU_SUB; end
      OP_ADDI:  begin alu_src_o = SRC_IMM; ovf_chk_o = 1'b1; end
      OP_ADDIU: alu_src_o = SRC_IMM;
      OP_SLTI:  begin alu_src_o = SRC_IMM; alu_ctr = ALU_SLT; end
      OP_SLTIU: begin alu_src_o = SRC_IMM; alu_ctr = ALU_SLTU; end
      OP_ANDI:  begin alu_src_o = SRC_IMM; alu_ctr = ALU_AND; ext_op_o = 1'b0; end
      OP_ORI:   begin alu_src_o = SRC_IMM; alu_ctr = ALU_OR;  ext_op_o = 1'b0; end
      OP_XORI:  begin alu_src_o = SRC_IMM; alu_ctr = ALU_XOR; ext_op_o = 1'b0; end
      // rs is $0 for LUI, so OR passes the shifted immediate through
      OP_LUI:   begin alu_src_o = SRC_UPPER; alu_ctr = ALU_OR; end
      OP_LW:    begin alu_src_o = SRC_IMM; iclass = CLS_LW; end
      OP_SW:    begin alu_src_o = SRC_IMM; iclass = CLS_SW; end
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller for the A0 MIPS datapath: sequences fetch,
// decode, execute, memory and writeback, holds the IR, and traps on
// memory timeout, illegal encodings and (optionally) signed overflow.
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int ALUCTR_W    = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int OVF_TRAP    = 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [WORD_W-1:0]   instr,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                alu_zf,
  input  logic                alu_vf,
  output logic                iREN,
  output logic                dREN,
  output logic                dWEN,
  output logic                IRWr,
  output logic                PCWr,
  output logic [1:0]          PCSrc,
  output logic                RegWr,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemToReg,
  output logic [1:0]          ALUSrc,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                ExtOp,
  output logic                shamt_sel,
  output logic                halt,
  output logic [1:0]          err
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  ctrl_state_t       state_q;
  logic [CNT_W-1:0]  wait_q;
  logic [WORD_W-1:0] ir_q;
  logic              halt_q;
  ctrl_err_t         err_q;

  logic [3:0]   dec_alu_ctr;
  logic [1:0]   dec_alu_src;
  logic         dec_ext_op;
  logic         dec_rtype;
  logic         dec_shamt_sel;
  logic [2:0]   dec_iclass;
  logic         dec_ovf_chk;
  logic         dec_illegal;
  instr_class_t iclass;
  logic         timeout;
  logic         ovf_trap;
  logic         unused_ir;

  instr_decoder u_decoder (
    .opcode_i    (ir_q[31:26]),
    .funct_i     (ir_q[5:0]),
    .alu_ctr_o   (dec_alu_ctr),
    .alu_src_o   (dec_alu_src),
    .ext_op_o    (dec_ext_op),
    .rtype_o     (dec_rtype),
    .shamt_sel_o (dec_shamt_sel),
    .iclass_o    (dec_iclass),
    .ovf_chk_o   (dec_ovf_chk),
    .illegal_o   (dec_illegal)
  );

  // Register fields are consumed by the datapath, not by control
  assign unused_ir = ^ir_q[25:6];

  assign iclass   = instr_class_t'(dec_iclass);
  assign timeout  = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_CNT);
  assign ovf_trap = (OVF_TRAP != 0) && dec_ovf_chk && alu_vf;
  assign halt     = halt_q;
  assign err      = err_q;

  // Sequencing: state, instruction register, wait counter, sticky halt/error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      wait_q  <= '0;
      ir_q    <= '0;
      halt_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state_q)
        FETCH: begin
          if (ihit) begin
            ir_q   <= instr;
            wait_q <= '0;
            if (instr[31:26] == OP_HALT) begin
              state_q <= HALT;
              halt_q  <= 1'b1;
            end else begin
              state_q <= DECODE;
            end
          end else if (timeout) begin
            state_q <= HALT;
            halt_q  <= 1'b1;
            err_q   <= ERR_MEM_TIMEOUT;
          end else if (wait_q != '1) begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        DECODE: begin
          wait_q <= '0;
          if (dec_illegal) begin
            state_q <= HALT;
            halt_q  <= 1'b1;
            err_q   <= ERR_ILLEGAL;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          wait_q <= '0;
          case (iclass)
            CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_JR: state_q <= FETCH;
            CLS_LW, CLS_SW:                           state_q <= MEM;
            default: begin
              if (ovf_trap) begin
                state_q <= HALT;
                halt_q  <= 1'b1;
                err_q   <= ERR_OVERFLOW;
              end else begin
                state_q <= WB;
              end
            end
          endcase
        end
        MEM: begin
          if (dhit) begin
            wait_q  <= '0;
            state_q <= (iclass == CLS_LW) ? WB : FETCH;
          end else if (timeout) begin
            state_q <= HALT;
            halt_q  <= 1'b1;
            err_q   <= ERR_MEM_TIMEOUT;
          end else if (wait_q != '1) begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        WB: begin
          wait_q  <= '0;
          state_q <= FETCH;
        end
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Control outputs from state and IR; all of them drop while nRST is low
  always_comb begin
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    IRWr      = 1'b0;
    PCWr      = 1'b0;
    PCSrc     = PCSRC_NEXT;
    RegWr     = 1'b0;
    RegDst    = REGDST_RT;
    MemToReg  = WBSRC_ALU;
    ALUSrc    = SRC_RT;
    ALUctr    = '0;
    ExtOp     = 1'b0;
    shamt_sel = 1'b0;
    if (nRST) begin
      if (state_q inside {DECODE, EXEC, MEM, WB}) begin
        ExtOp     = dec_ext_op;
        ALUSrc    = dec_alu_src;
        ALUctr    = ALUCTR_W'(dec_alu_ctr);
        shamt_sel = dec_shamt_sel;
      end
      case (state_q)
        FETCH: begin
          iREN = 1'b1;
          IRWr = ihit;
          PCWr = ihit;
        end
        EXEC: begin
          case (iclass)
            CLS_BEQ: begin PCWr = alu_zf;  PCSrc = PCSRC_BRANCH; end
            CLS_BNE: begin PCWr = !alu_zf; PCSrc = PCSRC_BRANCH; end
            CLS_J:   begin PCWr = 1'b1;    PCSrc = PCSRC_JUMP;   end
            CLS_JAL: begin
              PCWr     = 1'b1;
              PCSrc    = PCSRC_JUMP;
              RegWr    = 1'b1;
              RegDst   = REGDST_R31;
              MemToReg = WBSRC_PC4;
            end
            CLS_JR:  begin PCWr = 1'b1;    PCSrc = PCSRC_RS;     end
            default: ;
          endcase
        end
        MEM: begin
          dREN = (iclass == CLS_LW);
          dWEN = (iclass == CLS_SW);
        end
        WB: begin
          RegWr    = 1'b1;
          RegDst   = dec_rtype ? REGDST_RD : REGDST_RT;
          MemToReg = (iclass == CLS_LW) ? WBSRC_DLOAD : WBSRC_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors
// for each instruction class, memory timeout, overflow trap and reset.
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] instr;
  logic        ihit, dhit, alu_zf, alu_vf;

  logic       iREN, dREN, dWEN, IRWr, PCWr, RegWr, ExtOp, shamt_sel, halt;
  logic [1:0] PCSrc, RegDst, MemToReg, ALUSrc, err;
  logic [3:0] ALUctr;

  logic       nt_iREN, nt_dREN, nt_dWEN, nt_IRWr, nt_PCWr, nt_RegWr, nt_ExtOp, nt_shamt_sel, nt_halt;
  logic [1:0] nt_PCSrc, nt_RegDst, nt_MemToReg, nt_ALUSrc, nt_err;
  logic [3:0] nt_ALUctr;
  logic       unused_nt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .OVF_TRAP(1)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit),
    .alu_zf(alu_zf), .alu_vf(alu_vf), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .RegWr(RegWr), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUctr(ALUctr), .ExtOp(ExtOp),
    .shamt_sel(shamt_sel), .halt(halt), .err(err)
  );

  // Same stimulus, overflow trapping disabled
  multicycle_control_unit #(.MEM_TIMEOUT(4), .OVF_TRAP(0)) dut_nt (
    .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit),
    .alu_zf(alu_zf), .alu_vf(alu_vf), .iREN(nt_iREN), .dREN(nt_dREN), .dWEN(nt_dWEN),
    .IRWr(nt_IRWr), .PCWr(nt_PCWr), .PCSrc(nt_PCSrc), .RegWr(nt_RegWr), .RegDst(nt_RegDst),
    .MemToReg(nt_MemToReg), .ALUSrc(nt_ALUSrc), .ALUctr(nt_ALUctr), .ExtOp(nt_ExtOp),
    .shamt_sel(nt_shamt_sel), .halt(nt_halt), .err(nt_err)
  );

  assign unused_nt = ^{nt_iREN, nt_dREN, nt_dWEN, nt_IRWr, nt_PCWr, nt_ExtOp, nt_shamt_sel,
                       nt_PCSrc, nt_RegDst, nt_MemToReg, nt_ALUSrc, nt_ALUctr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compares the packed handshake/enable vector against hand-written values
  task automatic ck_ctl(input string tag, input logic iren, input logic dren, input logic dwen,
                        input logic irwr, input logic pcwr, input logic [1:0] pcsrc,
                        input logic regwr, input logic [1:0] regdst, input logic [1:0] m2r,
                        input logic h, input logic [1:0] e);
    check(tag,
          {17'b0, iREN, dREN, dWEN, IRWr, PCWr, PCSrc, RegWr, RegDst, MemToReg, halt, err},
          {17'b0, iren, dren, dwen, irwr, pcwr, pcsrc, regwr, regdst, m2r, h, e});
  endtask

  // One clock cycle: drive inputs just after the falling edge, sample 1 ns later
  task automatic step(input logic ih, input logic dh, input logic zf, input logic vf);
    @(negedge CLK);
    ihit = ih; dhit = dh; alu_zf = zf; alu_vf = vf;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; alu_zf = 1'b0; alu_vf = 1'b0;
    #1;
    ck_ctl("rst_low", 0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    @(posedge CLK);
    #2 nRST = 1'b1;
    #1;
    ck_ctl("rst_fetch", 1,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
  endtask

  initial begin
    nRST = 1'b0; instr = '0; ihit = 1'b0; dhit = 1'b0; alu_zf = 1'b0; alu_vf = 1'b0;
    do_reset();

    // ADDU $3,$1,$2 : F D E W
    instr = 32'h00221821;
    step(1,0,0,0); ck_ctl("addu_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0); ck_ctl("addu_D", 0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    check("addu_extop", ExtOp, 1);
    step(0,0,0,0); ck_ctl("addu_E", 0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    check("addu_aluctr", ALUctr, 2);
    check("addu_alusrc", ALUSrc, 0);
    step(0,0,0,0); ck_ctl("addu_W", 0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0);

    // LW $4,8($0) with three wait cycles : F D E M M M M W
    instr = 32'h8C040008;
    step(1,0,0,0); ck_ctl("lw_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0); check("lw_D_extop", ExtOp, 1);
    step(0,0,0,0); check("lw_E_alusrc", ALUSrc, 1);
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0); ck_ctl("lw_M_wait", 0,1,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    end
    step(0,1,0,0); ck_ctl("lw_M_hit", 0,1,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0); ck_ctl("lw_W", 0,0,0,0,0,2'd0,1,2'd0,2'd1,0,2'd0);

    // BEQ taken
    instr = 32'h10220004;
    step(1,0,0,0); ck_ctl("beq1_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0);
    step(0,0,1,0); ck_ctl("beq1_E", 0,0,0,0,1,2'd2,0,2'd0,2'd0,0,2'd0);
    check("beq_aluctr", ALUctr, 3);
    // BEQ not taken
    step(1,0,0,0); ck_ctl("beq0_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0);
    step(0,0,0,0); ck_ctl("beq0_E", 0,0,0,0,0,2'd2,0,2'd0,2'd0,0,2'd0);
    // BNE with zf=0 is taken
    instr = 32'h14220004;
    step(1,0,0,0); ck_ctl("bne_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0);
    step(0,0,0,0); ck_ctl("bne_E", 0,0,0,0,1,2'd2,0,2'd0,2'd0,0,2'd0);

    // JAL
    instr = 32'h0C000010;
    step(1,0,0,0); ck_ctl("jal_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0);
    step(0,0,0,0); ck_ctl("jal_E", 0,0,0,0,1,2'd1,1,2'd2,2'd2,0,2'd0);
    // JR $31
    instr = 32'h03E00008;
    step(1,0,0,0); ck_ctl("jr_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0);
    step(0,0,0,0); ck_ctl("jr_E", 0,0,0,0,1,2'd3,0,2'd0,2'd0,0,2'd0);

    // SW $5,4($0), zero-wait : F D E M
    instr = 32'hAC050004;
    step(1,0,0,0); ck_ctl("sw_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0);
    step(0,0,0,0);
    step(0,1,0,0); ck_ctl("sw_M", 0,0,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0);

    // ORI zero-extends
    instr = 32'h34210005;
    step(1,0,0,0); ck_ctl("ori_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0); check("ori_D_extop", ExtOp, 0);
    step(0,0,0,0); check("ori_E_aluctr", ALUctr, 5);
    step(0,0,0,0); ck_ctl("ori_W", 0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0);

    // SLL $2,$2,2 selects shamt
    instr = 32'h00021080;
    step(1,0,0,0);
    step(0,0,0,0);
    step(0,0,0,0); check("sll_shamt_sel", shamt_sel, 1);
    check("sll_aluctr", ALUctr, 0);
    step(0,0,0,0); ck_ctl("sll_W", 0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0);

    // ADD $3,$1,$2 overflowing: trap on dut, writeback on dut_nt
    instr = 32'h00221820;
    step(1,0,0,0);
    step(0,0,0,0);
    step(0,0,0,1); ck_ctl("ovf_E", 0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0); ck_ctl("ovf_halt", 0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd3);
    check("ovf_nt_regwr", nt_RegWr, 1);
    check("ovf_nt_halt", nt_halt, 0);
    step(1,1,1,0); ck_ctl("ovf_sticky", 0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd3);
    do_reset();

    // Fetch timeout: no ihit for five FETCH cycles
    for (int i = 0; i < 5; i++) begin
      step(0,0,0,0); ck_ctl("to_fetch_wait", 1,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    end
    step(0,0,0,0); ck_ctl("to_halt", 0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd1);
    do_reset();

    // ihit on the timeout cycle wins
    instr = 32'h00221821;
    for (int i = 0; i < 4; i++) step(0,0,0,0);
    step(1,0,0,0); ck_ctl("to_hit_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0); ck_ctl("to_hit_D", 0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    check("to_hit_D_extop", ExtOp, 1);
    step(0,0,0,0);
    step(0,0,0,0); ck_ctl("to_hit_W", 0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0);

    // Illegal opcode 6'h01
    instr = 32'h04000000;
    step(1,0,0,0);
    step(0,0,0,0); ck_ctl("ill_D", 0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    step(0,0,0,0); ck_ctl("ill_halt", 0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2);
    do_reset();

    // HALT opcode
    instr = 32'hFC000000;
    step(1,0,0,0); ck_ctl("halt_F", 1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd0);
    step(1,0,0,0); ck_ctl("halt_set", 0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0);
    step(1,1,1,1); ck_ctl("halt_stays", 0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0);
    do_reset();

    // Reset asserted mid-MEM drops the request immediately
    instr = 32'h8C040008;
    step(1,0,0,0);
    step(0,0,0,0);
    step(0,0,0,0);
    step(0,0,0,0); ck_ctl("mid_M", 0,1,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    nRST = 1'b0;
    #1;
    ck_ctl("mid_async_drop", 0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle FSM controller for the A0 MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback over several cycles, handshaking with the memory arbiter through ihit/dhit.
- Holds the current instruction in an internal IR. Decodes it into datapath controls, with configurable memory timeout and overflow trapping.
- Sits between the datapath and the arbiter. Drives PC, IR, register file, ALU and memory request enables.

Parameters:
- WORD_W, 32, instruction and data width.
- ALUCTR_W, 4, width of ALUctr (aluop_t).
- MEM_TIMEOUT, 255, max wait cycles for ihit/dhit before mem_err; 0 disables the timeout.
- OVF_TRAP, 1, 1 = signed overflow on ADD/SUB/ADDI halts and suppresses writeback; 0 = overflow ignored.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- instr  in  WORD_W  instruction word from the arbiter (imemload)
- ihit  in  1  instruction fetch complete
- dhit  in  1  data access complete
- alu_zf  in  1  ALU zero flag
- alu_vf  in  1  ALU signed overflow flag
- iREN  out  1  instruction read request
- dREN  out  1  data read request
- dWEN  out  1  data write request
- IRWr  out  1  load IR (pulse)
- PCWr  out  1  load PC (pulse)
- PCSrc  out  2  0 = PC+4, 1 = jump target, 2 = branch target, 3 = rs
- RegWr  out  1  register file write enable
- RegDst  out  2  0 = rt, 1 = rd, 2 = r31
- MemToReg  out  2  0 = ALU, 1 = dload, 2 = PC+4
- ALUSrc  out  2  0 = rt, 1 = ext imm16, 2 = imm16<<16
- ALUctr  out  ALUCTR_W  ALU operation
- ExtOp  out  1  1 = sign-extend imm16, 0 = zero-extend
- shamt_sel  out  1  ALU port A takes shamt (SLL/SRL)
- halt  out  1  registered, sticky halt
- err  out  2  0 = none, 1 = mem timeout, 2 = illegal opcode, 3 = overflow

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset -> FETCH, wait counter 0, IR 0, halt 0, err 0.
- All outputs are Moore, decoded from state and IR. In FETCH after reset, iREN=1; every other output is 0.
- Fields: opcode=IR[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- FETCH:
  - iREN=1 until ihit.
  - On ihit: IRWr=1, PCWr=1, PCSrc=0, next state DECODE.
  - If IR opcode is HALT (6'h3F), go to HALT instead; IRWr still fires.
- DECODE:
  - One cycle; ExtOp valid. ORI/ANDI/XORI zero-extend; all others sign-extend.
  - Illegal opcode/funct -> HALT with err=2.
- EXEC:
  - ALUctr and ALUSrc valid.
  - BEQ/BNE: PCWr = (zf for BEQ, !zf for BNE), PCSrc=2, next state FETCH.
  - J: PCWr=1, PCSrc=1, next state FETCH.
  - JAL: as J, plus RegWr=1, RegDst=2, MemToReg=2.
  - JR: PCWr=1, PCSrc=3, next state FETCH.
  - LW/SW -> MEM.
  - All others -> WB.
  - OVF_TRAP=1 and alu_vf on ADD/SUB/ADDI -> HALT with err=3; no WB.
- MEM:
  - LW: dREN=1 until dhit, then WB.
  - SW: dWEN=1 until dhit, then FETCH.
- WB: RegWr=1 for one cycle. RegDst=1 for R-type, 0 for I-type. MemToReg=1 for LW, else 0. Next state FETCH.
- HALT: all enables 0, halt=1. Only nRST exits.
- Latency with zero-wait memory:
  - R/I-ALU: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - branch/J/JAL/JR: 3 cycles
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle without a hit.
  - MEM_TIMEOUT>0 and counter==MEM_TIMEOUT with no hit -> HALT, err=1.
  - A hit on the timeout cycle wins.
  - The counter saturates and does not wrap.
- err is set only on entry to HALT. Holds until reset.
- Reset asserted mid-operation:
  - All requests drop immediately (asynchronously).
  - No RegWr/PCWr pulse completes.

Decomposition:
- cpu_types_pkg: add ctrl_state_t enum (FETCH..HALT) and ctrl_err_t. Reuse existing opcode_t, funct_t and aluop_t.
- One sub-module: instr_decoder (combinational). Maps opcode/funct to ALUctr, ALUSrc, ExtOp, RegDst, shamt_sel, instruction class and illegal flag.
- The FSM, counter and IR stay in multicycle_control_unit.

Test Plan:
- ADDU $3,$1,$2 (0x00221821), ihit on the first FETCH cycle -> states F,D,E,W. RegWr=1, RegDst=1 in cycle 4. Next FETCH in cycle 5.
- LW $4,8($0) with dhit after 3 wait cycles -> dREN high for 4 cycles, then WB. MemToReg=1; total 8 cycles.
- BEQ with alu_zf=1 -> PCWr=1, PCSrc=2 in EXEC. With alu_zf=0 -> PCWr=0. Both return to FETCH after 3 cycles.
- MEM_TIMEOUT=4, ihit never asserted -> halt=1, err=1 after 5 FETCH cycles. With ihit on the 5th cycle -> normal DECODE instead.
- ADD overflowing (alu_vf=1), OVF_TRAP=1 -> HALT, err=3, no RegWr. With OVF_TRAP=0 -> WB proceeds.
- HALT opcode 0xFC000000 -> halt rises after FETCH and stays set. nRST pulse in any state -> FETCH, halt=0, err=0.
